// File: rtl/m_imem_loader_pkg.sv
// m_imem_loader_pkg: shared state encodings and defaults for the UART instruction-memory loader
package m_imem_loader_pkg;
    localparam int DEF_CLKS_PER_BIT = 434;
    localparam int DEF_ADDR_W = 12;
    typedef enum logic [1:0] {L_CNT, L_DATA, L_DONE} ld_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/m_imem_loader_uart_rx.sv
// m_uart_rx: 8N1 receiver with 2-flop synchroniser, mid-bit sampling and start-glitch rejection
module m_uart_rx
    import m_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       w_clk,
    input  logic       w_rst,
    input  logic       w_rxd,
    output logic [7:0] r_byte,
    output logic       r_valid,
    output logic       r_ferr,
    output logic       r_active
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    rx_state_t st, st_n;
    logic s1, s2, sp;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bits, bits_n;
    logic [7:0] sh, sh_n, byte_n;
    logic valid_n, ferr_n;
    // start is considered confirmed in the cycle the mid-start sample reads low
    assign r_active = (st == RX_START && cnt == HALF && !s2) || st == RX_DATA || st == RX_STOP;
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            sp <= 1'b1;
            st <= RX_IDLE;
            cnt <= '0;
            bits <= '0;
            sh <= '0;
            r_byte <= '0;
            r_valid <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            s1 <= w_rxd;
            s2 <= s1;
            sp <= s2;
            st <= st_n;
            cnt <= cnt_n;
            bits <= bits_n;
            sh <= sh_n;
            r_byte <= byte_n;
            r_valid <= valid_n;
            r_ferr <= ferr_n;
        end
    end
    always_comb begin
        st_n = st;
        cnt_n = cnt + CW'(1);
        bits_n = bits;
        sh_n = sh;
        byte_n = r_byte;
        valid_n = 1'b0;
        ferr_n = 1'b0;
        case (st)
            RX_IDLE: begin
                cnt_n = '0;
                st_n = (sp && !s2) ? RX_START : RX_IDLE;
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_n = '0;
                    bits_n = '0;
                    st_n = s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_n = '0;
                    sh_n = {s2, sh[7:1]};
                    bits_n = bits + 3'd1;
                    st_n = (bits == 3'd7) ? RX_STOP : RX_DATA;
                end
            end
            default: begin
                if (cnt == FULL) begin
                    cnt_n = '0;
                    st_n = RX_IDLE;
                    byte_n = sh;
                    valid_n = s2;
                    ferr_n = !s2;
                end
            end
        endcase
    end
endmodule

// File: rtl/m_imem_loader.sv
// m_imem_loader: receives a little-endian program image over UART and writes it into instruction memory,
// holding the processor in reset via r_busy while a load is in progress
module m_imem_loader
    import m_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_rxd,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic [31:0]       r_data,
    output logic              r_busy,
    output logic              r_done,
    output logic              r_err
);
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;
    ld_state_t st, st_n;
    logic [1:0] bcnt, bcnt_n;
    logic [ADDR_W-1:0] last, last_n, addr_n;
    logic [31:0] data_n, word;
    logic we_n, busy_n, done_n, err_n;
    logic [7:0] rx_byte;
    logic rx_valid, rx_ferr, rx_active;
    m_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .w_clk(w_clk),
        .w_rst(w_rst),
        .w_rxd(w_rxd),
        .r_byte(rx_byte),
        .r_valid(rx_valid),
        .r_ferr(rx_ferr),
        .r_active(rx_active)
    );
    // r_data doubles as the byte shift register; new bytes enter at the top so the first lands in [7:0]
    assign word = {rx_byte, r_data[31:8]};
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            st <= L_CNT;
            bcnt <= '0;
            last <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_we <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err <= 1'b0;
        end else begin
            st <= st_n;
            bcnt <= bcnt_n;
            last <= last_n;
            r_addr <= addr_n;
            r_data <= data_n;
            r_we <= we_n;
            r_busy <= busy_n;
            r_done <= done_n;
            r_err <= err_n;
        end
    end
    always_comb begin
        st_n = st;
        bcnt_n = rx_valid ? bcnt + 2'd1 : bcnt;
        last_n = last;
        addr_n = r_addr;
        data_n = rx_valid ? word : r_data;
        we_n = 1'b0;
        done_n = 1'b0;
        busy_n = r_busy;
        err_n = r_err;
        case (st)
            L_CNT: begin
                busy_n = r_busy | rx_active;
                if (rx_valid && bcnt == 2'd3) begin
                    if (word == '0) begin
                        st_n = L_DONE;
                        done_n = 1'b1;
                        busy_n = 1'b0;
                    end else if (word > MAX_WORDS) begin
                        err_n = 1'b1;
                        busy_n = 1'b0;
                    end else begin
                        st_n = L_DATA;
                        addr_n = '0;
                        last_n = ADDR_W'(word - 32'd1);
                    end
                end
            end
            L_DATA: begin
                we_n = rx_valid && bcnt == 2'd3;
                if (r_we && r_addr == last) begin
                    st_n = L_DONE;
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end else if (r_we) begin
                    addr_n = r_addr + ADDR_W'(1);
                end
            end
            default: begin
                st_n = L_CNT;
                bcnt_n = '0;
            end
        endcase
        // a bad stop bit abandons whatever was being assembled
        if (rx_ferr) begin
            st_n = L_CNT;
            bcnt_n = '0;
            we_n = 1'b0;
            done_n = 1'b0;
            busy_n = 1'b0;
            err_n = 1'b1;
        end
    end
endmodule
